instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/next_pc.sv | 30 +++
 rtl/instr_fetch.sv | 87 ++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and the next-PC select encoding
// produced by decode.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        PC_SEQ = 3'd0,
        PC_JR  = 3'd2,
        PC_J   = 3'd3,
        PC_BNE = 3'd4,
        PC_BEQ = 3'd5
    } pcsrc_t;

endpackage

// File: rtl/next_pc.sv
// Combinational next-PC select: sequential, jump-register, jump, and the two
// conditional branches. Unlisted select codes fall through to sequential.
module next_pc
    import cpu_types_pkg::*;
(
    input  word_t       npc,
    input  logic [2:0]  pcsrc,
    input  logic        zero,
    input  word_t       rdat1,
    input  logic [25:0] jaddr,
    input  logic [15:0] imm16,
    output word_t       next
);

    word_t branch_target;

    assign branch_target = npc + {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        next = npc;
        case (pcsrc_t'(pcsrc))
            PC_JR:   next = rdat1 & 32'hFFFF_FFFC;
            PC_J:    next = {npc[31:28], jaddr, 2'b00};
            PC_BNE:  next = zero ? npc : branch_target;
            PC_BEQ:  next = zero ? branch_target : npc;
            default: next = npc;
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// Multi-cycle instruction fetch: requests a word at pc, holds it for decode
// until retired, then advances pc via next_pc. HALT parks the unit for good.
//
// state  | meaning
// FETCH  | iREN high at imemaddr=pc, waiting for ihit
// EXEC   | instr valid for decode; retires when stall drops
// HALTED | HALT retired; frozen until reset
module instr_fetch
    import cpu_types_pkg::*;
#(
    parameter word_t PC0 = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  word_t       imemload,
    input  logic        stall,
    input  logic        halt,
    input  logic [2:0]  PCsrc,
    input  logic        zero,
    input  word_t       rdat1,
    input  logic [25:0] jaddr,
    input  logic [15:0] imm16,
    output logic        iREN,
    output word_t       imemaddr,
    output word_t       instr,
    output logic        instr_valid,
    output word_t       pc,
    output word_t       npc,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state;
    word_t  pc_next;

    assign npc = pc + 32'd4;

    next_pc u_next_pc (
        .npc   (npc),
        .pcsrc (PCsrc),
        .zero  (zero),
        .rdat1 (rdat1),
        .jaddr (jaddr),
        .imm16 (imm16),
        .next  (pc_next)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= FETCH;
            pc    <= PC0;
            instr <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (ihit) begin
                        instr <= imemload;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    // halt wins over stall so a stalled HALT still stops the core
                    if (halt) begin
                        state <= HALTED;
                    end else if (!stall) begin
                        pc    <= pc_next;
                        state <= FETCH;
                    end
                end
                HALTED:  state <= HALTED;
                default: state <= FETCH;
            endcase
        end
    end

    assign iREN        = (state == FETCH);
    assign imemaddr    = pc;
    assign instr_valid = (state == EXEC);
    assign halted      = (state == HALTED);

endmodule
